// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between dcache and icache, tracks load-tag ownership, routes returns.
// Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int NUM_TAGS     = 15,
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 64,
  parameter int TAG_W        = $clog2(NUM_TAGS + 1),
  parameter int OCNT_W       = $clog2(NUM_TAGS + 1)
`ifdef MEM_ARB_STATS_EN
  ,
  parameter int CNT_W        = 16
`endif
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [1:0]        dcache_command_i,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic [DATA_W-1:0] dcache_data_i,
  input  logic [1:0]        icache_command_i,
  input  logic [ADDR_W-1:0] icache_addr_i,
  input  logic [TAG_W-1:0]  mem2proc_transaction_tag_i,
  input  logic [DATA_W-1:0] mem2proc_data_i,
  input  logic [TAG_W-1:0]  mem2proc_data_tag_i,
  output logic [1:0]        proc2mem_command_o,
  output logic [ADDR_W-1:0] proc2mem_addr_o,
  output logic [DATA_W-1:0] proc2mem_data_o,
  output logic [TAG_W-1:0]  dcache_transaction_tag_o,
  output logic [TAG_W-1:0]  icache_transaction_tag_o,
  output logic [DATA_W-1:0] dcache_data_o,
  output logic [TAG_W-1:0]  dcache_data_tag_o,
  output logic [DATA_W-1:0] icache_data_o,
  output logic [TAG_W-1:0]  icache_data_tag_o,
  output logic [OCNT_W-1:0] outstanding_cnt_o,
  output logic              tag_error_o
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_dgrant_o,
  output logic [CNT_W-1:0]  stat_igrant_o,
  output logic [CNT_W-1:0]  stat_icache_stall_o
`endif
);

  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_LOAD = 2'd1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TAG_W-1:0] TAG_NONE = {TAG_W{1'b0}};

  logic [NUM_TAGS:0]  valid_q, valid_d;
  logic [NUM_TAGS:0]  owner_q, owner_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic               tag_error_q, tag_error_d;
  logic [OCNT_W-1:0]  cnt_q, cnt_d;

  logic dcache_req_s, icache_req_s, grant_d_s, grant_i_s;
  logic accepted_s, alloc_s, ret_hit_s, ret_miss_s;

  // Grant selection and forwarding of the winner's request to memory
  always_comb begin
    dcache_req_s = (dcache_command_i != MEM_NONE);
    icache_req_s = (icache_command_i != MEM_NONE);
    grant_d_s    = 1'b0;
    grant_i_s    = 1'b0;
    if (icache_req_s && (starve_q == STARVE_MAX)) begin
      grant_i_s = 1'b1;
    end else if (dcache_req_s) begin
      grant_d_s = 1'b1;
    end else if (icache_req_s) begin
      grant_i_s = 1'b1;
    end else begin
      grant_d_s = 1'b0;
    end
    proc2mem_command_o       = MEM_NONE;
    proc2mem_addr_o          = {ADDR_W{1'b0}};
    proc2mem_data_o          = {DATA_W{1'b0}};
    dcache_transaction_tag_o = TAG_NONE;
    icache_transaction_tag_o = TAG_NONE;
    if (grant_d_s) begin
      proc2mem_command_o       = dcache_command_i;
      proc2mem_addr_o          = dcache_addr_i;
      proc2mem_data_o          = dcache_data_i;
      dcache_transaction_tag_o = mem2proc_transaction_tag_i;
    end else if (grant_i_s) begin
      proc2mem_command_o       = icache_command_i;
      proc2mem_addr_o          = icache_addr_i;
      icache_transaction_tag_o = mem2proc_transaction_tag_i;
    end else begin
      proc2mem_command_o = MEM_NONE;
    end
    accepted_s = (grant_d_s || grant_i_s) && (mem2proc_transaction_tag_i != TAG_NONE);
    alloc_s    = accepted_s && (proc2mem_command_o == MEM_LOAD);
  end

  // Return-data routing to the recorded owner of the tag
  always_comb begin
    ret_hit_s         = (mem2proc_data_tag_i != TAG_NONE) && valid_q[mem2proc_data_tag_i];
    ret_miss_s        = (mem2proc_data_tag_i != TAG_NONE) && !valid_q[mem2proc_data_tag_i];
    dcache_data_o     = {DATA_W{1'b0}};
    dcache_data_tag_o = TAG_NONE;
    icache_data_o     = {DATA_W{1'b0}};
    icache_data_tag_o = TAG_NONE;
    if (ret_hit_s && owner_q[mem2proc_data_tag_i]) begin
      icache_data_o     = mem2proc_data_i;
      icache_data_tag_o = mem2proc_data_tag_i;
    end else if (ret_hit_s) begin
      dcache_data_o     = mem2proc_data_i;
      dcache_data_tag_o = mem2proc_data_tag_i;
    end else begin
      dcache_data_tag_o = TAG_NONE;
    end
  end

  // Next state: a same-cycle allocation overrides a return of the same tag
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    if (ret_hit_s) begin
      valid_d[mem2proc_data_tag_i] = 1'b0;
    end else begin
      valid_d[0] = 1'b0;
    end
    if (alloc_s) begin
      valid_d[mem2proc_transaction_tag_i] = 1'b1;
      owner_d[mem2proc_transaction_tag_i] = grant_i_s;
    end else begin
      owner_d[0] = 1'b0;
    end
    tag_error_d = tag_error_q | ret_miss_s;
    cnt_d = {OCNT_W{1'b0}};
    for (int i = 1; i <= NUM_TAGS; i++) begin
      cnt_d = cnt_d + {{(OCNT_W-1){1'b0}}, valid_d[i]};
    end
    if (icache_req_s && (icache_transaction_tag_o == TAG_NONE)) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1'b1);
    end else begin
      starve_d = {SW{1'b0}};
    end
  end

  // Owner table, starvation counter and status registers
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q     <= {(NUM_TAGS+1){1'b0}};
      owner_q     <= {(NUM_TAGS+1){1'b0}};
      starve_q    <= {SW{1'b0}};
      tag_error_q <= 1'b0;
      cnt_q       <= {OCNT_W{1'b0}};
    end else begin
      valid_q     <= valid_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      tag_error_q <= tag_error_d;
      cnt_q       <= cnt_d;
    end
  end

  assign outstanding_cnt_o = cnt_q;
  assign tag_error_o       = tag_error_q;

`ifdef MEM_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [CNT_W-1:0] dgr_q, igr_q, stall_q;

  // Saturating grant and stall statistics
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      dgr_q   <= {CNT_W{1'b0}};
      igr_q   <= {CNT_W{1'b0}};
      stall_q <= {CNT_W{1'b0}};
    end else begin
      if (accepted_s && grant_d_s && (dgr_q != CNT_MAX)) dgr_q <= dgr_q + CNT_W'(1'b1);
      if (accepted_s && grant_i_s && (igr_q != CNT_MAX)) igr_q <= igr_q + CNT_W'(1'b1);
      if (icache_req_s && (icache_transaction_tag_o == TAG_NONE) && (stall_q != CNT_MAX))
        stall_q <= stall_q + CNT_W'(1'b1);
    end
  end

  assign stat_dgrant_o       = dgr_q;
  assign stat_igrant_o       = igr_q;
  assign stat_icache_stall_o = stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default build, statistics disabled).
module tb_mem_port_arbiter;
  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic        clock_i, reset_i;
  logic [1:0]  dcache_command_i, icache_command_i;
  logic [31:0] dcache_addr_i, icache_addr_i;
  logic [63:0] dcache_data_i, mem2proc_data_i;
  logic [3:0]  mem2proc_transaction_tag_i, mem2proc_data_tag_i;
  logic [1:0]  proc2mem_command_o;
  logic [31:0] proc2mem_addr_o;
  logic [63:0] proc2mem_data_o, dcache_data_o, icache_data_o;
  logic [3:0]  dcache_transaction_tag_o, icache_transaction_tag_o;
  logic [3:0]  dcache_data_tag_o, icache_data_tag_o, outstanding_cnt_o;
  logic        tag_error_o;

  int total_cnt = 0;
  int bad_cnt   = 0;

  mem_port_arbiter dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .dcache_command_i(dcache_command_i), .dcache_addr_i(dcache_addr_i), .dcache_data_i(dcache_data_i),
    .icache_command_i(icache_command_i), .icache_addr_i(icache_addr_i),
    .mem2proc_transaction_tag_i(mem2proc_transaction_tag_i),
    .mem2proc_data_i(mem2proc_data_i), .mem2proc_data_tag_i(mem2proc_data_tag_i),
    .proc2mem_command_o(proc2mem_command_o), .proc2mem_addr_o(proc2mem_addr_o),
    .proc2mem_data_o(proc2mem_data_o),
    .dcache_transaction_tag_o(dcache_transaction_tag_o),
    .icache_transaction_tag_o(icache_transaction_tag_o),
    .dcache_data_o(dcache_data_o), .dcache_data_tag_o(dcache_data_tag_o),
    .icache_data_o(icache_data_o), .icache_data_tag_o(icache_data_tag_o),
    .outstanding_cnt_o(outstanding_cnt_o), .tag_error_o(tag_error_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tg, obs, exp);
    end
  endtask

  task automatic apply(input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                       input logic [1:0] ic, input logic [31:0] ia, input logic [3:0] mt,
                       input logic [3:0] rt, input logic [63:0] rd);
    dcache_command_i = dc; dcache_addr_i = da; dcache_data_i = dd;
    icache_command_i = ic; icache_addr_i = ia;
    mem2proc_transaction_tag_i = mt; mem2proc_data_tag_i = rt; mem2proc_data_i = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b0;
    apply(NONE, 32'h0, 64'h0, NONE, 32'h0, 4'd0, 4'd0, 64'h0);
    #10;
    chk("rst_cmd", proc2mem_command_o, NONE);
    chk("rst_cnt", outstanding_cnt_o, 4'd0);
    chk("rst_err", tag_error_o, 1'b0);
    reset_i = 1'b1;
    tick();

    // 1: dcache load alone, then its return
    apply(LOAD, 32'h100, 64'h0, NONE, 32'h0, 4'd3, 4'd0, 64'h0);
    chk("t1_cmd", proc2mem_command_o, LOAD);
    chk("t1_addr", proc2mem_addr_o, 32'h100);
    chk("t1_dtag", dcache_transaction_tag_o, 4'd3);
    chk("t1_itag", icache_transaction_tag_o, 4'd0);
    tick();
    chk("t1_cnt1", outstanding_cnt_o, 4'd1);
    apply(NONE, 32'h0, 64'h0, NONE, 32'h0, 4'd0, 4'd3, 64'hAB);
    chk("t1_rdtag", dcache_data_tag_o, 4'd3);
    chk("t1_rdata", dcache_data_o, 64'hAB);
    chk("t1_ritag", icache_data_tag_o, 4'd0);
    tick();
    chk("t1_cnt0", outstanding_cnt_o, 4'd0);

    // 2: both request, memory always accepts with tag 5
    for (int k = 0; k < 6; k++) begin
      apply(LOAD, 32'h300, 64'h0, LOAD, 32'h400, 4'd5, 4'd0, 64'h0);
      if (k == 4) begin
        chk("t2_iwin_itag", icache_transaction_tag_o, 4'd5);
        chk("t2_iwin_dtag", dcache_transaction_tag_o, 4'd0);
        chk("t2_iwin_addr", proc2mem_addr_o, 32'h400);
      end else begin
        chk("t2_dwin_dtag", dcache_transaction_tag_o, 4'd5);
        chk("t2_dwin_itag", icache_transaction_tag_o, 4'd0);
        chk("t2_dwin_addr", proc2mem_addr_o, 32'h300);
      end
      tick();
    end
    apply(NONE, 32'h0, 64'h0, NONE, 32'h0, 4'd0, 4'd0, 64'h0);
    tick();
    chk("t2_cnt", outstanding_cnt_o, 4'd1);
    apply(NONE, 32'h0, 64'h0, NONE, 32'h0, 4'd0, 4'd5, 64'h5);
    chk("t2_ret_dtag", dcache_data_tag_o, 4'd5);
    tick();
    chk("t2_cnt0", outstanding_cnt_o, 4'd0);

    // 3: build up starvation, then forced icache grant rejected twice
    for (int k = 0; k < 4; k++) begin
      apply(LOAD, 32'h300, 64'h77, LOAD, 32'h400, 4'd6, 4'd0, 64'h0);
      chk("t3_pre_dtag", dcache_transaction_tag_o, 4'd6);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      apply(LOAD, 32'h300, 64'h77, LOAD, 32'h400, (k == 2) ? 4'd7 : 4'd0, 4'd0, 64'h0);
      chk("t3_f_addr", proc2mem_addr_o, 32'h400);
      chk("t3_f_data", proc2mem_data_o, 64'h0);
      chk("t3_f_dtag", dcache_transaction_tag_o, 4'd0);
      chk("t3_f_itag", icache_transaction_tag_o, (k == 2) ? 4'd7 : 4'd0);
      tick();
    end
    apply(NONE, 32'h0, 64'h0, NONE, 32'h0, 4'd0, 4'd0, 64'h0);
    tick();
    chk("t3_cnt2", outstanding_cnt_o, 4'd2);
    apply(NONE, 32'h0, 64'h0, NONE, 32'h0, 4'd0, 4'd7, 64'hC0DE);
    chk("t3_r7_itag", icache_data_tag_o, 4'd7);
    chk("t3_r7_idata", icache_data_o, 64'hC0DE);
    chk("t3_r7_dtag", dcache_data_tag_o, 4'd0);
    tick();
    apply(NONE, 32'h0, 64'h0, NONE, 32'h0, 4'd0, 4'd6, 64'h66);
    chk("t3_r6_dtag", dcache_data_tag_o, 4'd6);
    tick();
    chk("t3_cnt0", outstanding_cnt_o, 4'd0);

    // 5: same-cycle return and reallocation of tag 4
    apply(LOAD, 32'h500, 64'h0, NONE, 32'h0, 4'd4, 4'd0, 64'h0);
    tick();
    chk("t5_cnt1", outstanding_cnt_o, 4'd1);
    apply(NONE, 32'h0, 64'h0, LOAD, 32'h600, 4'd4, 4'd4, 64'h44);
    chk("t5_dret_tag", dcache_data_tag_o, 4'd4);
    chk("t5_dret_data", dcache_data_o, 64'h44);
    chk("t5_iret_tag", icache_data_tag_o, 4'd0);
    chk("t5_itag", icache_transaction_tag_o, 4'd4);
    tick();
    chk("t5_cnt_same", outstanding_cnt_o, 4'd1);
    apply(NONE, 32'h0, 64'h0, NONE, 32'h0, 4'd0, 4'd4, 64'h45);
    chk("t5_new_owner", icache_data_tag_o, 4'd4);
    chk("t5_old_owner", dcache_data_tag_o, 4'd0);
    tick();
    chk("t5_cnt0", outstanding_cnt_o, 4'd0);
    chk("t5_noerr", tag_error_o, 1'b0);

    // 4: return of a tag that was never allocated
    apply(NONE, 32'h0, 64'h0, NONE, 32'h0, 4'd0, 4'd9, 64'h99);
    chk("t4_dtag", dcache_data_tag_o, 4'd0);
    chk("t4_itag", icache_data_tag_o, 4'd0);
    tick();
    chk("t4_err", tag_error_o, 1'b1);
    apply(NONE, 32'h0, 64'h0, NONE, 32'h0, 4'd0, 4'd0, 64'h0);
    tick();
    chk("t4_sticky", tag_error_o, 1'b1);

    // 6: store allocates nothing; reset mid-run clears state
    apply(STORE, 32'h200, 64'h55, NONE, 32'h0, 4'd2, 4'd0, 64'h0);
    chk("t6_cmd", proc2mem_command_o, STORE);
    chk("t6_addr", proc2mem_addr_o, 32'h200);
    chk("t6_data", proc2mem_data_o, 64'h55);
    chk("t6_dtag", dcache_transaction_tag_o, 4'd2);
    tick();
    chk("t6_cnt0", outstanding_cnt_o, 4'd0);
    apply(LOAD, 32'h210, 64'h0, NONE, 32'h0, 4'd8, 4'd0, 64'h0);
    tick();
    chk("t6_cnt1", outstanding_cnt_o, 4'd1);
    apply(NONE, 32'h0, 64'h0, NONE, 32'h0, 4'd0, 4'd0, 64'h0);
    reset_i = 1'b0;
    #1;
    chk("t6_rst_cnt", outstanding_cnt_o, 4'd0);
    chk("t6_rst_err", tag_error_o, 1'b0);
    reset_i = 1'b1;
    apply(NONE, 32'h0, 64'h0, NONE, 32'h0, 4'd0, 4'd8, 64'h88);
    chk("t6_orphan_dtag", dcache_data_tag_o, 4'd0);
    tick();
    chk("t6_orphan_err", tag_error_o, 1'b1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
